clock_set_ctrl: RTL and testbench

- Sequencing/configuration controller for the 12-hour BCD time-of-day counter (pm/hh/mm/ss, reset 12:00:00 AM).
- Generates the counter's one-cycle `ena` tick from a prescaler and runs a button-driven set-mode FSM.
- Loads edited time into the counter and holds and compares an alarm time.
- Sits between the debounced front-panel buttons and the counter.

---
 rtl/clock_set_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Set-mode sequencer, tick prescaler and alarm compare for the 12-hour BCD clock counter.
// Optional snooze re-arm is built when SNOOZE_EN is defined.
module clock_set_ctrl #(
    parameter int DIV          = 4,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       alarm_arm,
    input  logic       cur_pm,
    input  logic [7:0] cur_hh,
    input  logic [7:0] cur_mm,
    input  logic [7:0] cur_ss,
    output logic       ena,
    output logic       ld,
    output logic       ld_pm,
    output logic [7:0] ld_hh,
    output logic [7:0] ld_mm,
    output logic [7:0] ld_ss,
    output logic [2:0] mode,
    output logic       alarm
);

    localparam int PW = $clog2(DIV);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_HH    = 3'd1,
        SET_MM    = 3'd2,
        SET_AL_HH = 3'd3,
        SET_AL_MM = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          ed_pm_q, ed_pm_d, al_pm_q, al_pm_d, ld_pm_q, ld_pm_d;
    logic [7:0]    ed_hh_q, ed_hh_d, al_hh_q, al_hh_d, ld_hh_q, ld_hh_d;
    logic [7:0]    ed_mm_q, ed_mm_d, al_mm_q, al_mm_d, ld_mm_q, ld_mm_d;
    logic          ld_q, ld_d;
    logic          match_c, match_q;
    logic          alarm_q, alarm_d;
    logic          leave_run, alarm_clr, alarm_set, snz_fire;
    logic [8:0]    ed_hh_nx, al_hh_nx;

    // Returns {pm_toggle, next_hh}; 11 -> 12 is the only step that flips AM/PM.
    function automatic logic [8:0] hh_inc(input logic [7:0] hh);
        logic [8:0] r;
        if (hh == 8'h12)            r = {1'b0, 8'h01};
        else if (hh == 8'h11)       r = {1'b1, 8'h12};
        else if (hh[3:0] == 4'h9)   r = {1'b0, hh[7:4] + 4'h1, 4'h0};
        else                        r = {1'b0, hh[7:4], hh[3:0] + 4'h1};
        return r;
    endfunction

    function automatic logic [7:0] mm_inc(input logic [7:0] mm);
        logic [7:0] r;
        if (mm == 8'h59)            r = 8'h00;
        else if (mm[3:0] == 4'h9)   r = {mm[7:4] + 4'h1, 4'h0};
        else                        r = {mm[7:4], mm[3:0] + 4'h1};
        return r;
    endfunction

    assign ed_hh_nx = hh_inc(ed_hh_q);
    assign al_hh_nx = hh_inc(al_hh_q);

    assign ena   = (state_q == RUN) && (pre_q == PW'(DIV - 1));
    assign ld    = ld_q;
    assign ld_pm = ld_pm_q;
    assign ld_hh = ld_hh_q;
    assign ld_mm = ld_mm_q;
    assign ld_ss = 8'h00;
    assign mode  = state_q;
    assign alarm = alarm_q;

    always_comb begin
        state_d = state_q;
        ed_pm_d = ed_pm_q;
        ed_hh_d = ed_hh_q;
        ed_mm_d = ed_mm_q;
        al_pm_d = al_pm_q;
        al_hh_d = al_hh_q;
        al_mm_d = al_mm_q;
        ld_d    = 1'b0;
        ld_pm_d = ld_pm_q;
        ld_hh_d = ld_hh_q;
        ld_mm_d = ld_mm_q;
        // btn_mode is tested first in every state so a coincident btn_inc is dropped
        unique case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = SET_HH;
                    ed_pm_d = cur_pm;
                    ed_hh_d = cur_hh;
                    ed_mm_d = cur_mm;
                end
            end
            SET_HH: begin
                if (btn_mode) state_d = SET_MM;
                else if (btn_inc) begin
                    ed_hh_d = ed_hh_nx[7:0];
                    ed_pm_d = ed_pm_q ^ ed_hh_nx[8];
                end
            end
            SET_MM: begin
                if (btn_mode) begin
                    state_d = SET_AL_HH;
                    ld_d    = 1'b1;
                    ld_pm_d = ed_pm_q;
                    ld_hh_d = ed_hh_q;
                    ld_mm_d = ed_mm_q;
                end else if (btn_inc) ed_mm_d = mm_inc(ed_mm_q);
            end
            SET_AL_HH: begin
                if (btn_mode) state_d = SET_AL_MM;
                else if (btn_inc) begin
                    al_hh_d = al_hh_nx[7:0];
                    al_pm_d = al_pm_q ^ al_hh_nx[8];
                end
            end
            SET_AL_MM: begin
                if (btn_mode) state_d = RUN;
                else if (btn_inc) al_mm_d = mm_inc(al_mm_q);
            end
            default: state_d = RUN;
        endcase
    end

    // Prescaler only runs while staying in RUN; it re-enters RUN from zero.
    always_comb begin
        pre_d = '0;
        if (state_q == RUN && state_d == RUN)
            pre_d = ena ? '0 : pre_q + PW'(1);
    end

    assign match_c   = (state_q == RUN) && alarm_arm &&
                       ({cur_pm, cur_hh, cur_mm, cur_ss} == {al_pm_q, al_hh_q, al_mm_q, 8'h00});
    assign leave_run = (state_q != RUN) || btn_mode;
    assign alarm_clr = leave_run || !alarm_arm || btn_inc;
    assign alarm_set = (match_c && !match_q) || snz_fire;

    always_comb begin
        alarm_d = alarm_q;
        if (alarm_clr)      alarm_d = 1'b0;
        else if (alarm_set) alarm_d = 1'b1;
    end

`ifdef SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_TICKS + 1);

    logic [SW-1:0] snz_cnt_q, snz_cnt_d;
    logic          snz_act_q, snz_act_d;

    assign snz_fire = snz_act_q && ena && (snz_cnt_q == SW'(1));

    always_comb begin
        snz_cnt_d = snz_cnt_q;
        snz_act_d = snz_act_q;
        if (leave_run || !alarm_arm) begin
            snz_act_d = 1'b0;
        end else if (btn_inc && alarm_q) begin
            snz_act_d = 1'b1;
            snz_cnt_d = SW'(SNOOZE_TICKS);
        end else if (snz_act_q && ena) begin
            snz_cnt_d = snz_cnt_q - SW'(1);
            if (snz_fire) snz_act_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snz_cnt_q <= '0;
            snz_act_q <= 1'b0;
        end else begin
            snz_cnt_q <= snz_cnt_d;
            snz_act_q <= snz_act_d;
        end
    end
`else
    // Without snooze the alarm only re-arms through a fresh match edge.
    assign snz_fire = (SNOOZE_TICKS < 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            pre_q   <= '0;
            ed_pm_q <= 1'b0;
            ed_hh_q <= 8'h12;
            ed_mm_q <= 8'h00;
            al_pm_q <= 1'b0;
            al_hh_q <= 8'h12;
            al_mm_q <= 8'h00;
            ld_q    <= 1'b0;
            ld_pm_q <= 1'b0;
            ld_hh_q <= 8'h12;
            ld_mm_q <= 8'h00;
            match_q <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ed_pm_q <= ed_pm_d;
            ed_hh_q <= ed_hh_d;
            ed_mm_q <= ed_mm_d;
            al_pm_q <= al_pm_d;
            al_hh_q <= al_hh_d;
            al_mm_q <= al_mm_d;
            ld_q    <= ld_d;
            ld_pm_q <= ld_pm_d;
            ld_hh_q <= ld_hh_d;
            ld_mm_q <= ld_mm_d;
            match_q <= match_c;
            alarm_q <= alarm_d;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table for edits/loads, hand sequences for alarm/snooze/reset,
// and a randomized run against an integer-time reference model checked every cycle.
module tb_clock_set_ctrl;
    localparam int DIV = 4;
    localparam int SNZ = 3;

    logic       clk = 0, reset_n = 0;
    logic       btn_mode = 0, btn_inc = 0, alarm_arm = 0, cur_pm = 0;
    logic [7:0] cur_hh = 8'h01, cur_mm = 8'h00, cur_ss = 8'h00;
    logic       ena, ld, ld_pm, alarm;
    logic [7:0] ld_hh, ld_mm, ld_ss;
    logic [2:0] mode;

    clock_set_ctrl #(.DIV(DIV), .SNOOZE_TICKS(SNZ)) dut (
        .clk(clk), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .alarm_arm(alarm_arm), .cur_pm(cur_pm), .cur_hh(cur_hh), .cur_mm(cur_mm),
        .cur_ss(cur_ss), .ena(ena), .ld(ld), .ld_pm(ld_pm), .ld_hh(ld_hh),
        .ld_mm(ld_mm), .ld_ss(ld_ss), .mode(mode), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    function automatic int bin(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Reference model: times as plain integers (hours 1..12, minutes 0..59).
    int m_mode = 0, m_run = 0, snz = 0;
    int e_hh = 12, e_mm = 0, a_hh = 12, a_mm = 0, l_hh = 12, l_mm = 0;
    bit e_pm = 0, a_pm = 0, l_pm = 0, m_ld = 0, m_alarm = 0, m_mprev = 0;
    bit m_en, m_match, m_clr, m_set, m_ack, m_fire;

    function automatic bit exp_ena();
        return (m_mode == 0) && ((m_run % DIV) == DIV - 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_run = 0; snz = 0;
            e_hh = 12; e_mm = 0; e_pm = 0;
            a_hh = 12; a_mm = 0; a_pm = 0;
            l_hh = 12; l_mm = 0; l_pm = 0;
            m_ld = 0; m_alarm = 0; m_mprev = 0;
        end else begin
            m_en    = exp_ena();
            m_match = (m_mode == 0) && alarm_arm && cur_pm == a_pm && bin(cur_hh) == a_hh &&
                      bin(cur_mm) == a_mm && cur_ss == 8'h00;
            m_ack   = (m_mode == 0) && btn_inc && !btn_mode && m_alarm;
            m_clr   = (m_mode != 0) || btn_mode || btn_inc || !alarm_arm;
            m_set   = m_match && !m_mprev;
            m_fire  = 0;
`ifdef SNOOZE_EN
            if (m_mode != 0 || btn_mode || !alarm_arm) snz = 0;
            else if (m_ack) snz = SNZ;
            else if (snz > 0 && m_en) begin
                snz--;
                if (snz == 0) m_fire = 1;
            end
`endif
            m_set   = m_set || m_fire;
            if (m_clr) m_alarm = 0;
            else if (m_set) m_alarm = 1;
            m_mprev = m_match;
            m_ld    = (m_mode == 2) && btn_mode;
            if (m_ld) begin l_pm = e_pm; l_hh = e_hh; l_mm = e_mm; end
            if (m_mode == 0 && !btn_mode) m_run++;
            else m_run = 0;
            if (btn_mode) begin
                if (m_mode == 0) begin e_pm = cur_pm; e_hh = bin(cur_hh); e_mm = bin(cur_mm); end
                m_mode = (m_mode + 1) % 5;
            end else if (btn_inc) begin
                case (m_mode)
                    1: begin if (e_hh == 11) e_pm = !e_pm; e_hh = e_hh % 12 + 1; end
                    2: e_mm = (e_mm + 1) % 60;
                    3: begin if (a_hh == 11) a_pm = !a_pm; a_hh = a_hh % 12 + 1; end
                    4: a_mm = (a_mm + 1) % 60;
                    default: ;
                endcase
            end
        end
    end

    logic [30:0] act_v, exp_v;
    always @(negedge clk) begin
        act_v = {ena, ld, ld_pm, ld_hh, ld_mm, ld_ss, mode, alarm};
        exp_v = {exp_ena(), m_ld, l_pm, bcd(l_hh), bcd(l_mm), 8'h00, 3'(m_mode), m_alarm};
        chk("model", 32'(act_v), 32'(exp_v));
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic smp();  @(negedge clk);     endtask

    typedef struct {
        logic cp; logic [7:0] ch, cm; int nh, nm;
        logic ep; logic [7:0] eh, em;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ne;
        bit done, exp_al;
        tbl[0] = '{1'b0, 8'h11, 8'h58, 1,  0,  1'b1, 8'h12, 8'h58};
        tbl[1] = '{1'b0, 8'h12, 8'h00, 1,  0,  1'b0, 8'h01, 8'h00};
        tbl[2] = '{1'b1, 8'h09, 8'h30, 1,  0,  1'b1, 8'h10, 8'h30};
        tbl[3] = '{1'b0, 8'h10, 8'h59, 0,  1,  1'b0, 8'h10, 8'h00};
        tbl[4] = '{1'b1, 8'h05, 8'h09, 0,  1,  1'b1, 8'h05, 8'h10};
        tbl[5] = '{1'b0, 8'h11, 8'h00, 2,  0,  1'b1, 8'h01, 8'h00};
        tbl[6] = '{1'b1, 8'h11, 8'h45, 1,  15, 1'b0, 8'h12, 8'h00};
        tbl[7] = '{1'b0, 8'h01, 8'h07, 12, 60, 1'b1, 8'h01, 8'h07};

        // reset state and prescaler cadence after release
        smp();
        chk("rst_mode", mode, 0); chk("rst_ena", ena, 0); chk("rst_ld", ld, 0);
        chk("rst_ld_hh", ld_hh, 8'h12); chk("rst_ld_mm", ld_mm, 0); chk("rst_alarm", alarm, 0);
        @(posedge clk); #1; reset_n = 1;
        for (int k = 1; k <= 12; k++) begin
            smp();
            chk("ena_cadence", ena, (k % 4) == 0);
            chk("run_ld", ld, 0);
            step();
        end

        // edit/load vectors
        for (int i = 0; i < 8; i++) begin
            cur_pm = tbl[i].cp; cur_hh = tbl[i].ch; cur_mm = tbl[i].cm; cur_ss = 8'h00;
            btn_mode = 1; step(); btn_mode = 0;
            for (int k = 0; k < tbl[i].nh; k++) begin btn_inc = 1; step(); end
            btn_inc = 0;
            btn_mode = 1; step(); btn_mode = 0;
            for (int k = 0; k < tbl[i].nm; k++) begin btn_inc = 1; step(); end
            btn_inc = 0;
            btn_mode = 1; step(); btn_mode = 0;
            smp();
            chk("vec_ld", ld, 1); chk("vec_ld_pm", ld_pm, tbl[i].ep);
            chk("vec_ld_hh", ld_hh, tbl[i].eh); chk("vec_ld_mm", ld_mm, tbl[i].em);
            chk("vec_ld_ss", ld_ss, 0); chk("vec_mode", mode, 3); chk("vec_ena", ena, 0);
            step(); smp();
            chk("vec_ld_once", ld, 0); chk("vec_ld_hold", ld_hh, tbl[i].eh);
            step();
            btn_mode = 1; step(); step(); btn_mode = 0;
        end

        // alarm 06:30 PM
        reset_n = 0; step(); reset_n = 1;
        btn_mode = 1; repeat (3) step(); btn_mode = 0;
        btn_inc = 1; repeat (18) step(); btn_inc = 0;
        btn_mode = 1; step(); btn_mode = 0;
        btn_inc = 1; repeat (30) step(); btn_inc = 0;
        btn_mode = 1; step(); btn_mode = 0;
        alarm_arm = 1; cur_pm = 0; cur_hh = 8'h01; cur_mm = 8'h00; cur_ss = 8'h00;
        repeat (2) step();
        cur_pm = 1; cur_hh = 8'h06; cur_mm = 8'h30; cur_ss = 8'h00;
        smp(); chk("al_first_match", alarm, 0);
        step(); smp(); chk("al_rise", alarm, 1);
        step(); smp(); chk("al_sticky", alarm, 1);
        step(); btn_inc = 1; step(); btn_inc = 0;
        ne = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            smp();
`ifdef SNOOZE_EN
            exp_al = (ne >= SNZ);
`else
            exp_al = 0;
`endif
            chk("al_ack_wait", alarm, exp_al);
            if (exp_al) done = 1;
            if (ena) ne++;
            step();
        end
`ifdef SNOOZE_EN
        checks++;
        if (!done) begin failures++; $display("FAIL snooze_timeout: got no re-assert expected alarm=1"); end
`endif
        cur_ss = 8'h01; step();
`ifdef SNOOZE_EN
        btn_inc = 1; step(); btn_inc = 0;
        ne = 0;
        for (int c = 0; c < 20 && ne < 2; c++) begin smp(); if (ena) ne++; step(); end
`endif
        alarm_arm = 0; step(); alarm_arm = 1;
        for (int c = 0; c < 16; c++) begin smp(); chk("snooze_cancel", alarm, 0); step(); end

        // mode and inc together in SET_MM, then reset mid-edit
        cur_pm = 0; cur_hh = 8'h03; cur_mm = 8'h10; cur_ss = 8'h00;
        btn_mode = 1; step(); step();
        btn_inc = 1; step(); btn_mode = 0; btn_inc = 0;
        smp();
        chk("both_ld", ld, 1); chk("both_ld_mm", ld_mm, 8'h10);
        chk("both_ld_hh", ld_hh, 8'h03); chk("both_mode", mode, 3);
        step(); btn_mode = 1; step(); step(); btn_mode = 0;
        btn_mode = 1; step(); btn_mode = 0;
        btn_inc = 1; step(); btn_inc = 0;
        #2; reset_n = 0; #1;
        chk("rst_mid_mode", mode, 0); chk("rst_mid_ena", ena, 0); chk("rst_mid_alarm", alarm, 0);
        chk("rst_mid_ld", ld, 0); chk("rst_mid_ld_hh", ld_hh, 8'h12);
        @(posedge clk); #1; reset_n = 1;

        // randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            int r;
            btn_mode  = ($urandom % 10) == 0;
            btn_inc   = ($urandom % 4) == 0;
            alarm_arm = ($urandom % 40) != 0;
            reset_n   = ($urandom % 500) != 0;
            r = $urandom % 4;
            if (r < 2) begin
                cur_pm = a_pm; cur_hh = bcd(a_hh); cur_mm = bcd(a_mm);
                cur_ss = (r == 0) ? 8'h00 : bcd($urandom % 2);
            end else begin
                cur_pm = 1'($urandom % 2); cur_hh = bcd(1 + $urandom % 12);
                cur_mm = bcd($urandom % 60); cur_ss = bcd($urandom % 60);
            end
            step();
        end
        reset_n = 1; btn_mode = 0; btn_inc = 0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
